// File: rtl/alu_pkg.sv
// ============================================================================
// Module : alu_pkg
// Desc   : Shared unit codes and packed-entry field layout for the ALU
//          result collector.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    // Unit codes tagged onto every captured result
    localparam logic [1:0] ARITH_U = 2'b00;
    localparam logic [1:0] LOGIC_U = 2'b01;
    localparam logic [1:0] CMP_U   = 2'b10;
    localparam logic [1:0] SHIFT_U = 2'b11;

    // Field widths of the metadata that sits above the data field
    localparam int CARRY_WD = 1;
    localparam int OP_WD    = 2;
    localparam int UNIT_WD  = 2;

    // Bit offsets measured from the top of the data field (i.e. add the
    // data width to get the absolute position inside a packed entry)
    localparam int CARRY_OFS = 0;
    localparam int OP_OFS    = CARRY_OFS + CARRY_WD;
    localparam int UNIT_OFS  = OP_OFS + OP_WD;
    localparam int PAR_OFS   = UNIT_OFS + UNIT_WD;
    localparam int META_WD   = PAR_OFS;

endpackage

`default_nettype wire

// File: rtl/alu_result_collector_result_fifo.sv
// ============================================================================
// Module : result_fifo
// Desc   : Generic synchronous FIFO with wrap-bit pointers; a push into a full
//          FIFO is accepted when a pop frees the slot in the same cycle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module result_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_AW = $clog2(DEPTH);

    logic [c_AW:0]      r_wr_ptr;
    logic [c_AW:0]      r_rd_ptr;
    logic [WIDTH-1:0]   r_mem [DEPTH];

    logic               w_empty;
    logic               w_full;
    logic               w_pop;
    logic               w_push;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]) &&
                     (r_wr_ptr[c_AW]     != r_rd_ptr[c_AW]);
    assign w_pop   = i_pop && !w_empty;
    assign w_push  = i_push && (!w_full || w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage is cleared too so the head output reads zero after reset
    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_mem
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_mem[i] <= '0;
                end else if (w_push && (r_wr_ptr[c_AW-1:0] == c_AW'(i))) begin
                    r_mem[i] <= i_data;
                end
            end
        end
    endgenerate

    assign o_data  = r_mem[r_rd_ptr[c_AW-1:0]];
    assign o_full  = w_full;
    assign o_empty = w_empty;

endmodule

`default_nettype wire

// File: rtl/alu_result_collector.sv
// ============================================================================
// Module : alu_result_collector
// Desc   : Captures the ALU's registered unit result, tags it with unit/op and
//          queues it on a valid/ready port. ALU_RESULT_PARITY_EN adds per-entry
//          even parity (RES_PAR) and a sticky parity error (PAR_ERR).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_result_collector
    import alu_pkg::*;
#(
    parameter int IN_WD    = 16,
    parameter int ARITH_WD = 2 * IN_WD,
    parameter int DEPTH    = 4,
    parameter int CNT_WD   = 8
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [3:0]          ALU_FUN,
    input  logic [ARITH_WD-1:0] ARITH_OUT,
    input  logic [IN_WD-1:0]    LOGIC_OUT,
    input  logic [IN_WD-1:0]    CMP_OUT,
    input  logic [IN_WD-1:0]    SHIFT_OUT,
    input  logic                CARRY_OUT,
    input  logic                ARITH_FLAG,
    input  logic                LOGIC_FLAG,
    input  logic                CMP_FLAG,
    input  logic                SHIFT_FLAG,
    output logic [ARITH_WD-1:0] RES_DATA,
    output logic [1:0]          RES_UNIT,
    output logic [1:0]          RES_OP,
    output logic                RES_CARRY,
    output logic                RES_VALID,
    input  logic                RES_READY,
    output logic                FULL,
    output logic [CNT_WD-1:0]   DROP_CNT,
    output logic                MULTI_ERR
`ifdef ALU_RESULT_PARITY_EN
    ,
    output logic                RES_PAR,
    output logic                PAR_ERR
`endif
);

`ifdef ALU_RESULT_PARITY_EN
    localparam int c_PAR_WD = 1;
`else
    localparam int c_PAR_WD = 0;
`endif
    localparam int c_ENTRY_WD = ARITH_WD + META_WD + c_PAR_WD;

    logic [3:0]            r_fun_d;
    logic [CNT_WD-1:0]     r_drop_cnt;
    logic                  r_multi_err;

    logic [3:0]            w_flags;
    logic                  w_capture;
    logic                  w_multi;
    logic [ARITH_WD-1:0]   w_data;
    logic [1:0]            w_unit;
    logic                  w_carry;
    logic [c_ENTRY_WD-1:0] w_entry;
    logic [c_ENTRY_WD-1:0] w_head;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_pop;
    logic                  w_drop;
    logic                  unused_fun_hi;

    assign w_flags   = {ARITH_FLAG, LOGIC_FLAG, CMP_FLAG, SHIFT_FLAG};
    assign w_capture = |w_flags;
    assign w_multi   = |(w_flags & (w_flags - 4'd1));

    // ALU results land one cycle after their opcode, so pair with the delayed copy
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_fun_d <= '0;
        else     r_fun_d <= ALU_FUN;
    end
    assign unused_fun_hi = ^r_fun_d[3:2];

    always_comb begin
        w_data  = '0;
        w_unit  = ARITH_U;
        w_carry = 1'b0;
        if (ARITH_FLAG) begin
            w_data  = ARITH_OUT;
            w_unit  = ARITH_U;
            w_carry = CARRY_OUT;
        end else if (LOGIC_FLAG) begin
            w_data  = ARITH_WD'(LOGIC_OUT);
            w_unit  = LOGIC_U;
        end else if (CMP_FLAG) begin
            w_data  = ARITH_WD'(CMP_OUT);
            w_unit  = CMP_U;
        end else if (SHIFT_FLAG) begin
            w_data  = ARITH_WD'(SHIFT_OUT);
            w_unit  = SHIFT_U;
        end
    end

    always_comb begin
        w_entry = '0;
        w_entry[ARITH_WD-1:0]                = w_data;
        w_entry[ARITH_WD + CARRY_OFS]        = w_carry;
        w_entry[ARITH_WD + OP_OFS +: OP_WD]  = r_fun_d[1:0];
        w_entry[ARITH_WD + UNIT_OFS +: UNIT_WD] = w_unit;
`ifdef ALU_RESULT_PARITY_EN
        w_entry[ARITH_WD + PAR_OFS] = ^w_entry[ARITH_WD + PAR_OFS - 1:0];
`endif
    end

    result_fifo #(
        .WIDTH (c_ENTRY_WD),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .rst     (RST),
        .i_push  (w_capture),
        .i_data  (w_entry),
        .i_pop   (RES_READY),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_pop  = !w_empty && RES_READY;
    assign w_drop = w_capture && w_full && !w_pop;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_drop_cnt  <= '0;
            r_multi_err <= 1'b0;
        end else begin
            if (w_drop && (r_drop_cnt != {CNT_WD{1'b1}})) r_drop_cnt <= r_drop_cnt + 1'b1;
            if (w_multi) r_multi_err <= 1'b1;
        end
    end

`ifdef ALU_RESULT_PARITY_EN
    logic r_par_err;

    // Even parity: the stored bit plus all covered fields must XOR to zero
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)                         r_par_err <= 1'b0;
        else if (w_pop && (^w_head))     r_par_err <= 1'b1;
    end

    assign RES_PAR = w_head[ARITH_WD + PAR_OFS];
    assign PAR_ERR = r_par_err;
`endif

    assign RES_DATA  = w_head[ARITH_WD-1:0];
    assign RES_CARRY = w_head[ARITH_WD + CARRY_OFS];
    assign RES_OP    = w_head[ARITH_WD + OP_OFS +: OP_WD];
    assign RES_UNIT  = w_head[ARITH_WD + UNIT_OFS +: UNIT_WD];
    assign RES_VALID = !w_empty;
    assign FULL      = w_full;
    assign DROP_CNT  = r_drop_cnt;
    assign MULTI_ERR = r_multi_err;

endmodule

`default_nettype wire

// File: tb/tb_alu_result_collector.sv
// ============================================================================
// Module : tb_alu_result_collector
// Desc   : Directed self-checking bench with a queue-based reference model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_result_collector;

    localparam int IN_WD    = 16;
    localparam int ARITH_WD = 32;
    localparam int DEPTH    = 4;
    localparam int CNT_WD   = 8;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [3:0]          alu_fun = '0;
    logic [ARITH_WD-1:0] arith_out = '0;
    logic [IN_WD-1:0]    logic_out = '0;
    logic [IN_WD-1:0]    cmp_out = '0;
    logic [IN_WD-1:0]    shift_out = '0;
    logic                carry_out = 1'b0;
    logic                arith_flag = 1'b0;
    logic                logic_flag = 1'b0;
    logic                cmp_flag = 1'b0;
    logic                shift_flag = 1'b0;
    logic                res_ready = 1'b0;
    logic [ARITH_WD-1:0] res_data;
    logic [1:0]          res_unit;
    logic [1:0]          res_op;
    logic                res_carry;
    logic                res_valid;
    logic                full;
    logic [CNT_WD-1:0]   drop_cnt;
    logic                multi_err;

    alu_result_collector #(
        .IN_WD(IN_WD), .ARITH_WD(ARITH_WD), .DEPTH(DEPTH), .CNT_WD(CNT_WD)
    ) dut (
        .CLK(clk), .RST(rst), .ALU_FUN(alu_fun),
        .ARITH_OUT(arith_out), .LOGIC_OUT(logic_out), .CMP_OUT(cmp_out),
        .SHIFT_OUT(shift_out), .CARRY_OUT(carry_out),
        .ARITH_FLAG(arith_flag), .LOGIC_FLAG(logic_flag),
        .CMP_FLAG(cmp_flag), .SHIFT_FLAG(shift_flag),
        .RES_DATA(res_data), .RES_UNIT(res_unit), .RES_OP(res_op),
        .RES_CARRY(res_carry), .RES_VALID(res_valid), .RES_READY(res_ready),
        .FULL(full), .DROP_CNT(drop_cnt), .MULTI_ERR(multi_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of tagged results
    typedef struct {
        logic [ARITH_WD-1:0] data;
        logic [1:0]          unit;
        logic [1:0]          op;
        logic                carry;
    } ent_t;

    ent_t        mq[$];
    logic [1:0]  m_fun_d;
    int          m_drop;
    logic        m_multi;

    always @(posedge clk or posedge rst) begin : model
        bit   pop;
        bit   was_full;
        int   nflags;
        ent_t e;
        if (rst) begin
            mq.delete();
            m_fun_d = 2'b00;
            m_drop  = 0;
            m_multi = 1'b0;
        end else begin
            pop      = (mq.size() != 0) && res_ready;
            was_full = (mq.size() == DEPTH);
            nflags   = int'(arith_flag) + int'(logic_flag) + int'(cmp_flag) + int'(shift_flag);
            if (nflags > 1) m_multi = 1'b1;
            if (pop) void'(mq.pop_front());
            if (nflags > 0) begin
                e.op    = m_fun_d;
                e.carry = 1'b0;
                if (arith_flag) begin
                    e.data = arith_out; e.unit = 2'd0; e.carry = carry_out;
                end else if (logic_flag) begin
                    e.data = {16'h0, logic_out}; e.unit = 2'd1;
                end else if (cmp_flag) begin
                    e.data = {16'h0, cmp_out}; e.unit = 2'd2;
                end else begin
                    e.data = {16'h0, shift_out}; e.unit = 2'd3;
                end
                if (!was_full || pop) mq.push_back(e);
                else if (m_drop < 255) m_drop = m_drop + 1;
            end
            m_fun_d = alu_fun[1:0];
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("m_valid", res_valid, mq.size() != 0);
            check("m_full", full, mq.size() == DEPTH);
            check("m_drop", drop_cnt, m_drop);
            check("m_multi", multi_err, m_multi);
            if (mq.size() != 0) begin
                check("m_data", res_data, mq[0].data);
                check("m_unit", res_unit, mq[0].unit);
                check("m_op", res_op, mq[0].op);
                check("m_carry", res_carry, mq[0].carry);
            end
        end
    end

    // Drive one cycle of inputs (flags: {arith, logic, cmp, shift}) and land at posedge+2
    task automatic tick(input logic [3:0] fun, input logic [3:0] fl,
                        input logic [31:0] a, input logic [15:0] l,
                        input logic [15:0] c, input logic [15:0] s,
                        input logic cy, input logic rdy);
        alu_fun    = fun;
        arith_flag = fl[3]; logic_flag = fl[2]; cmp_flag = fl[1]; shift_flag = fl[0];
        arith_out  = a; logic_out = l; cmp_out = c; shift_out = s;
        carry_out  = cy; res_ready = rdy;
        @(posedge clk);
        #2;
    endtask

    initial begin
        #7;
        check("rst_valid", res_valid, 0);
        check("rst_full", full, 0);
        check("rst_drop", drop_cnt, 0);
        check("rst_multi", multi_err, 0);
        check("rst_data", res_data, 0);
        check("rst_unit", res_unit, 0);
        check("rst_op", res_op, 0);
        check("rst_carry", res_carry, 0);
        rst = 1'b0;

        // Single arith capture with one-cycle opcode alignment
        tick(4'b0010, 4'b0000, 0, 0, 0, 0, 0, 0);
        tick(4'b0000, 4'b1000, 32'h0000_0190, 0, 0, 0, 0, 0);
        check("arith_valid", res_valid, 1);
        check("arith_data", res_data, 32'h190);
        check("arith_unit", res_unit, 2'b00);
        check("arith_op", res_op, 2'b10);
        check("arith_carry", res_carry, 0);
        tick(4'b0000, 4'b0000, 0, 0, 0, 0, 0, 1);
        check("arith_empty", res_valid, 0);

        // Shift result zero-extended, carry ignored for non-arith
        tick(4'b1101, 4'b0000, 0, 0, 0, 0, 0, 0);
        tick(4'b0000, 4'b0001, 0, 0, 0, 16'h8001, 1, 0);
        check("zx_data", res_data, 32'h0000_8001);
        check("zx_unit", res_unit, 2'b11);
        check("zx_op", res_op, 2'b01);
        check("zx_carry", res_carry, 0);
        tick(4'b0000, 4'b0000, 0, 0, 0, 0, 0, 1);

        // Overflow: five captures into four slots
        for (int i = 1; i <= 5; i++) tick(4'b0100, 4'b0100, 0, 16'(i), 0, 0, 0, 0);
        check("ovf_full", full, 1);
        check("ovf_drop", drop_cnt, 1);
        for (int i = 1; i <= 4; i++) begin
            check("ovf_order", res_data, i);
            tick(4'b0100, 4'b0000, 0, 0, 0, 0, 0, 1);
        end
        check("ovf_empty", res_valid, 0);

        // Full with simultaneous push and pop
        for (int i = 10; i <= 13; i++) tick(4'b0100, 4'b0100, 0, 16'(i), 0, 0, 0, 0);
        check("pp_full_before", full, 1);
        tick(4'b0100, 4'b0010, 0, 0, 16'h0003, 0, 0, 1);
        check("pp_full_after", full, 1);
        check("pp_drop", drop_cnt, 1);
        for (int i = 11; i <= 13; i++) begin
            check("pp_order", res_data, i);
            tick(4'b0100, 4'b0000, 0, 0, 0, 0, 0, 1);
        end
        check("pp_last_data", res_data, 32'h3);
        check("pp_last_unit", res_unit, 2'b10);
        tick(4'b0100, 4'b0000, 0, 0, 0, 0, 0, 1);
        check("pp_empty", res_valid, 0);

        // Drop counter saturation
        for (int i = 0; i < 4; i++) tick(4'b0100, 4'b0100, 0, 16'h00F0, 0, 0, 0, 0);
        for (int i = 0; i < 260; i++) tick(4'b0100, 4'b0100, 0, 16'h00F1, 0, 0, 0, 0);
        check("sat_drop", drop_cnt, 8'hFF);
        for (int i = 0; i < 4; i++) tick(4'b0100, 4'b0000, 0, 0, 0, 0, 0, 1);
        check("sat_empty", res_valid, 0);

        // Multiple flags: arith wins, sticky error
        tick(4'b0001, 4'b0000, 0, 0, 0, 0, 0, 0);
        tick(4'b0000, 4'b1100, 32'h1234_5678, 16'hFFFF, 0, 0, 1, 0);
        check("multi_unit", res_unit, 2'b00);
        check("multi_data", res_data, 32'h1234_5678);
        check("multi_carry", res_carry, 1);
        check("multi_op", res_op, 2'b01);
        check("multi_err", multi_err, 1);
        tick(4'b0000, 4'b0000, 0, 0, 0, 0, 0, 1);
        check("multi_single", res_valid, 0);
        for (int i = 0; i < 3; i++) tick(4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0);
        check("multi_sticky", multi_err, 1);

        // Asynchronous reset mid-stream
        tick(4'b0011, 4'b0000, 0, 0, 0, 0, 0, 0);
        for (int i = 7; i <= 9; i++) tick(4'b0011, 4'b0100, 0, 16'(i), 0, 0, 0, 0);
        check("mid_valid_before", res_valid, 1);
        alu_fun = 4'b0000; logic_flag = 1'b0;
        #3 rst = 1'b1;
        #1;
        check("mid_valid", res_valid, 0);
        check("mid_full", full, 0);
        check("mid_drop", drop_cnt, 0);
        check("mid_multi", multi_err, 0);
        #1 rst = 1'b0;
        tick(4'b0010, 4'b0001, 0, 0, 0, 16'h00AA, 0, 0);
        check("post_valid", res_valid, 1);
        check("post_data", res_data, 32'h00AA);
        check("post_unit", res_unit, 2'b11);
        check("post_op", res_op, 2'b00);
        tick(4'b0000, 4'b0000, 0, 0, 0, 0, 0, 1);
        check("post_sole", res_valid, 0);

        tick(4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
